csr_fence_ctrl: RTL and testbench

CSR_FENCE_CTRL -- requirements
Module: csr_fence_ctrl

---
 rtl/csr_fence_ctrl_if.sv | 32 +++
 rtl/csr_fence_ctrl.sv | 129 ++++++++++++
 tb/tb_csr_fence_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_fence_ctrl_if.sv
// Bundle of issue/commit/fence-query/unlock signals between the CSR fence controller and its neighbours.
// master = pipeline side, slave = csr_fence_ctrl.
interface csr_fence_ctrl_if #(
   parameter int NUM_WARPS = 4,
   parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
   logic                 issue_valid;
   logic [WID_W-1:0]     issue_wid;
   logic                 issue_fence;
   logic                 issue_ready;
   logic                 commit_valid;
   logic [WID_W-1:0]     commit_wid;
   logic [WID_W-1:0]     alm_empty_wid;
   logic                 alm_empty;
   logic                 unlock_valid;
   logic [WID_W-1:0]     unlock_wid;
   logic [NUM_WARPS-1:0] locked_mask;
   logic                 underflow_err;
   logic [31:0]          perf_lock_stalls;

   modport master (
      output issue_valid, issue_wid, issue_fence, commit_valid, commit_wid,
             alm_empty_wid, unlock_valid, unlock_wid,
      input  issue_ready, alm_empty, locked_mask, underflow_err, perf_lock_stalls
   );

   modport slave (
      input  issue_valid, issue_wid, issue_fence, commit_valid, commit_wid,
             alm_empty_wid, unlock_valid, unlock_wid,
      output issue_ready, alm_empty, locked_mask, underflow_err, perf_lock_stalls
   );
endinterface

// File: rtl/csr_fence_ctrl.sv
// Per-warp in-flight tracking and issue lock for FPU CSR fences (drain-before-access).
// Optional stall counter enabled by defining CSR_FENCE_PERF_EN.
module csr_fence_ctrl #(
   parameter int NUM_WARPS = 4,
   parameter int CNT_W     = 4,
   parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input logic              clk,
   input logic              reset_n,
   csr_fence_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] PMAX = '1;

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

   logic [1:0]       rst_sync_q;
   logic             rst_n_i;
   logic [CNT_W-1:0] pending_q [NUM_WARPS];
   logic [CNT_W-1:0] pending_d [NUM_WARPS];
   lock_state_t      st_q      [NUM_WARPS];
   lock_state_t      st_d      [NUM_WARPS];
   logic             uf_q;
   logic             uf_set;
   logic             issue_wid_ok, commit_wid_ok, alm_wid_ok, unlock_wid_ok;
   logic             issue_rdy, issue_acc;

   function automatic logic wid_ok(input logic [WID_W-1:0] wid);
      return {1'b0, wid} < (WID_W+1)'(NUM_WARPS);
   endfunction

   // Simultaneous +1/-1 cancel; decrement stops at zero instead of wrapping.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic inc, input logic dec);
      if (inc && !dec) return cur + CNT_W'(1);
      if (dec && !inc && cur != '0) return cur - CNT_W'(1);
      return cur;
   endfunction

   // Async assert, release aligned to clk through two flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_i = rst_sync_q[1];

   assign issue_wid_ok  = wid_ok(bus.issue_wid);
   assign commit_wid_ok = wid_ok(bus.commit_wid);
   assign alm_wid_ok    = wid_ok(bus.alm_empty_wid);
   assign unlock_wid_ok = wid_ok(bus.unlock_wid);

   always_comb begin
      issue_rdy = 1'b0;
      if (issue_wid_ok)
         issue_rdy = (st_q[bus.issue_wid] == UNLOCKED) && (pending_q[bus.issue_wid] != PMAX);
   end
   assign issue_acc       = bus.issue_valid && issue_rdy;
   assign bus.issue_ready = issue_rdy;

   always_comb begin
      bus.alm_empty = 1'b0;
      if (alm_wid_ok) bus.alm_empty = (pending_q[bus.alm_empty_wid] <= CNT_W'(1));
   end

   always_comb begin
      uf_set = 1'b0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         logic inc, dec;
         inc = issue_acc && (bus.issue_wid == WID_W'(i));
         dec = bus.commit_valid && commit_wid_ok && (bus.commit_wid == WID_W'(i));
         pending_d[i] = cnt_next(pending_q[i], inc, dec);
         if (dec && !inc && pending_q[i] == '0) uf_set = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_WARPS; i++) pending_q[i] <= '0;
         uf_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_WARPS; i++) pending_q[i] <= pending_d[i];
         uf_q <= uf_q | uf_set;
      end
   end
   assign bus.underflow_err = uf_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) for (int i = 0; i < NUM_WARPS; i++) st_q[i] <= UNLOCKED;
      else          for (int i = 0; i < NUM_WARPS; i++) st_q[i] <= st_d[i];
   end

   // A lock arriving with an unlock for the same warp wins.
   always_comb begin
      for (int i = 0; i < NUM_WARPS; i++) begin
         logic lock_i, unlock_i;
         lock_i   = issue_acc && bus.issue_fence && (bus.issue_wid == WID_W'(i));
         unlock_i = bus.unlock_valid && unlock_wid_ok && (bus.unlock_wid == WID_W'(i));
         st_d[i]  = st_q[i];
         case (st_q[i])
            UNLOCKED: if (lock_i)             st_d[i] = LOCKED;
            LOCKED:   if (unlock_i && !lock_i) st_d[i] = UNLOCKED;
            default:                           st_d[i] = UNLOCKED;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_WARPS; i++) bus.locked_mask[i] = (st_q[i] == LOCKED);
   end

`ifdef CSR_FENCE_PERF_EN
   logic [31:0] perf_q;
   logic        stall_hit;

   always_comb begin
      stall_hit = 1'b0;
      if (bus.issue_valid && issue_wid_ok) stall_hit = (st_q[bus.issue_wid] == LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i)       perf_q <= '0;
      else if (stall_hit) perf_q <= perf_q + 32'd1;
   end
   assign bus.perf_lock_stalls = perf_q;
`else
   assign bus.perf_lock_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_csr_fence_ctrl.sv
// Directed bench for csr_fence_ctrl: stimulus queues expected outputs per cycle, a monitor checks them.
module tb_csr_fence_ctrl;

   localparam int SIG_RDY = 0, SIG_ALM = 1, SIG_LOCK = 2, SIG_UF = 3, SIG_PERF = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   csr_fence_ctrl_if #(.NUM_WARPS(4), .WID_W(2)) bus ();

   csr_fence_ctrl #(.NUM_WARPS(4), .CNT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];

   function automatic logic [31:0] obs(input int sig);
      case (sig)
         SIG_RDY:  return {31'd0, bus.issue_ready};
         SIG_ALM:  return {31'd0, bus.alm_empty};
         SIG_LOCK: return {28'd0, bus.locked_mask};
         SIG_UF:   return {31'd0, bus.underflow_err};
         default:  return bus.perf_lock_stalls;
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle, away from the active edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] a;
         e = sb.pop_front();
         a = obs(e.sig);
         n_cmp++;
         if (a !== e.exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", e.name, cyc, a, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic iv, input logic [1:0] iw, input logic fn,
                      input logic cv, input logic [1:0] cw, input logic [1:0] aw,
                      input logic uv, input logic [1:0] uw);
      bus.issue_valid   = iv;
      bus.issue_wid     = iw;
      bus.issue_fence   = fn;
      bus.commit_valid  = cv;
      bus.commit_wid    = cw;
      bus.alm_empty_wid = aw;
      bus.unlock_valid  = uv;
      bus.unlock_wid    = uw;
   endtask

   task automatic chk(input int sig, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc;
      e.sig  = sig;
      e.exp  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] perf_exp(input int n);
`ifdef CSR_FENCE_PERF_EN
      return 32'(n);
`else
      return 32'd0 + 32'(n * 0);
`endif
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset values
      tick();
      chk(SIG_LOCK, 0, "rst_locked_mask");
      chk(SIG_UF,   0, "rst_underflow");
      chk(SIG_PERF, 0, "rst_perf");
      chk(SIG_ALM,  1, "rst_alm_empty");
      chk(SIG_RDY,  1, "rst_issue_ready");
      tick();
      reset_n = 1'b1;
      repeat (3) tick();

      // Three issues to wid 2, then drain two
      for (int k = 0; k < 3; k++) begin
         tick(); drv(1, 2, 0, 0, 0, 2, 0, 0);
         chk(SIG_RDY, 1, "t1_issue_ready");
         chk(SIG_ALM, (k <= 1) ? 32'd1 : 32'd0, "t1_alm_during_issue");
      end
      tick(); drv(0, 0, 0, 1, 2, 2, 0, 0); chk(SIG_ALM, 0, "t1_alm_p3");
      tick(); drv(0, 0, 0, 1, 2, 2, 0, 0); chk(SIG_ALM, 0, "t1_alm_p2");
      tick(); drv(0, 0, 0, 0, 0, 2, 0, 0); chk(SIG_ALM, 1, "t1_alm_p1");

      // Fence lock / unlock on wid 1
      tick(); drv(1, 1, 1, 0, 0, 0, 0, 0);
      chk(SIG_RDY, 1, "t2_fence_accept"); chk(SIG_LOCK, 0, "t2_mask_before");
      tick(); drv(0, 1, 0, 0, 0, 0, 0, 0);
      chk(SIG_LOCK, 2, "t2_mask_locked"); chk(SIG_RDY, 0, "t2_rdy_w1_locked");
      tick(); drv(0, 0, 0, 0, 0, 0, 1, 1);
      chk(SIG_RDY, 1, "t2_rdy_w0"); chk(SIG_LOCK, 2, "t2_mask_at_unlock");
      tick(); drv(0, 1, 0, 0, 0, 0, 0, 0);
      chk(SIG_LOCK, 0, "t2_mask_unlocked"); chk(SIG_RDY, 1, "t2_rdy_w1_unlocked");
      tick(); drv(0, 0, 0, 0, 0, 0, 1, 3); chk(SIG_LOCK, 0, "t2_unlock_idle_a");
      tick(); drv(0, 0, 0, 0, 0, 0, 0, 0); chk(SIG_LOCK, 0, "t2_unlock_idle_b");
      tick(); drv(1, 1, 1, 0, 0, 0, 1, 1); chk(SIG_RDY, 1, "t2_lock_unlock_same");
      tick(); drv(0, 1, 0, 0, 0, 0, 1, 1); chk(SIG_LOCK, 2, "t2_lock_wins");
      tick(); drv(0, 1, 0, 0, 0, 0, 0, 0); chk(SIG_LOCK, 0, "t2_relock_cleared");

      // Same-cycle issue+commit on wid 3 at pending 5
      for (int k = 0; k < 5; k++) begin
         tick(); drv(1, 3, 0, 0, 0, 3, 0, 0); chk(SIG_RDY, 1, "t3_fill_ready");
      end
      tick(); drv(1, 3, 0, 1, 3, 3, 0, 0);
      chk(SIG_RDY, 1, "t3_same_cycle_ready"); chk(SIG_ALM, 0, "t3_alm_p5");
      for (int k = 0; k < 4; k++) begin
         tick(); drv(0, 0, 0, 1, 3, 3, 0, 0); chk(SIG_ALM, 0, "t3_drain_alm");
      end
      tick(); drv(0, 0, 0, 0, 0, 3, 0, 0); chk(SIG_ALM, 1, "t3_pending_held_5");
      // Issue wid 2 with commit wid 3 in one cycle: both apply
      tick(); drv(1, 2, 0, 1, 3, 2, 0, 0); chk(SIG_ALM, 1, "t3_w2_p1");
      tick(); drv(0, 0, 0, 0, 0, 2, 0, 0); chk(SIG_ALM, 0, "t3_diff_issue_applied");
      tick(); drv(0, 0, 0, 1, 3, 3, 0, 0);
      chk(SIG_UF, 0, "t3_uf_before"); chk(SIG_ALM, 1, "t3_w3_empty");
      tick(); drv(0, 0, 0, 1, 0, 0, 0, 0); chk(SIG_UF, 1, "t3_uf_from_w3");
      tick(); drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk(SIG_UF, 1, "t3_uf_sticky"); chk(SIG_RDY, 1, "t3_w0_no_wrap");
      tick(); drv(0, 3, 0, 0, 0, 0, 0, 0);
      chk(SIG_RDY, 1, "t3_w3_no_wrap"); chk(SIG_UF, 1, "t3_uf_sticky2");

      // Counter saturation on wid 0
      for (int k = 0; k < 15; k++) begin
         tick(); drv(1, 0, 0, 0, 0, 0, 0, 0); chk(SIG_RDY, 1, "t4_fill_ready");
      end
      tick(); drv(1, 0, 0, 0, 0, 0, 0, 0); chk(SIG_RDY, 0, "t4_full_blocked");
      tick(); drv(0, 0, 0, 1, 0, 0, 0, 0); chk(SIG_RDY, 0, "t4_full_at_commit");
      tick(); drv(0, 0, 0, 0, 0, 0, 0, 0); chk(SIG_RDY, 1, "t4_after_commit");

      // Lock wid 2, hold issue, reset mid-window
      tick(); drv(1, 2, 1, 0, 0, 0, 0, 0);
      chk(SIG_RDY, 1, "t5_fence_accept"); chk(SIG_LOCK, 0, "t5_mask_before");
      for (int k = 1; k <= 4; k++) begin
         tick(); drv(1, 2, 0, 0, 0, 0, 0, 0);
         chk(SIG_LOCK, 4, "t5_mask_locked");
         chk(SIG_RDY, 0, "t5_rdy_locked");
         chk(SIG_PERF, perf_exp(k - 1), "t5_perf_count");
      end
      tick(); drv(1, 2, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      chk(SIG_LOCK, 0, "t5_async_mask");
      chk(SIG_PERF, 0, "t5_async_perf");
      chk(SIG_UF,   0, "t5_async_uf");
      chk(SIG_RDY,  1, "t5_async_ready");
      chk(SIG_ALM,  1, "t5_async_alm");
      for (int k = 0; k < 4; k++) begin
         tick(); drv(1, 2, 0, 0, 0, 0, 0, 0); chk(SIG_LOCK, 0, "t5_hold_mask");
      end
      tick(); reset_n = 1'b1; drv(0, 2, 0, 0, 0, 2, 0, 0);
      chk(SIG_RDY, 1, "t5_rel_ready_w2"); chk(SIG_ALM, 1, "t5_rel_alm_w2");
      chk(SIG_LOCK, 0, "t5_rel_mask");
      tick(); drv(0, 0, 0, 0, 0, 0, 0, 0); chk(SIG_RDY, 1, "t5_rel_ready_w0");
      repeat (3) tick();
      tick(); drv(1, 0, 0, 0, 0, 0, 0, 0);
      tick(); drv(1, 0, 0, 0, 0, 0, 0, 0);
      tick(); drv(0, 0, 0, 0, 0, 0, 0, 0); chk(SIG_ALM, 0, "post_rst_pending2");

      tick(); tick();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
